// File: rtl/control_pkg.sv
// ============================================================================
// control_pkg: FSM states, opcode/funct codes, ALUOp codes, decoded bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

package control_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_t;

  localparam logic [2:0] c_op_alu    = 3'b000;
  localparam logic [2:0] c_op_load   = 3'b001;
  localparam logic [2:0] c_op_store  = 3'b010;
  localparam logic [2:0] c_op_imm    = 3'b011;
  localparam logic [2:0] c_op_branch = 3'b100;
  localparam logic [2:0] c_op_mov    = 3'b101;
  localparam logic [2:0] c_op_shift  = 3'b110;
  localparam logic [2:0] c_op_logic  = 3'b111;

  localparam logic [1:0] c_fn_add = 2'b00;
  localparam logic [1:0] c_fn_sub = 2'b01;
  localparam logic [1:0] c_fn_and = 2'b00;
  localparam logic [1:0] c_fn_or  = 2'b01;
  localparam logic [1:0] c_fn_mul = 2'b10;

  localparam logic [3:0] c_alu_add  = 4'd0;
  localparam logic [3:0] c_alu_sub  = 4'd1;
  localparam logic [3:0] c_alu_lsl  = 4'd2;
  localparam logic [3:0] c_alu_asr  = 4'd3;
  localparam logic [3:0] c_alu_lsr  = 4'd4;
  localparam logic [3:0] c_alu_not  = 4'd5;
  localparam logic [3:0] c_alu_and  = 4'd6;
  localparam logic [3:0] c_alu_or   = 4'd7;
  localparam logic [3:0] c_alu_mul  = 4'd8;
  localparam logic [3:0] c_alu_pass = 4'b1111;

  typedef struct packed {
    logic [3:0] aluop;
    logic       alusrc;
    logic       mov;
    logic       load;
    logic       store;
    logic       branch;
    logic       mul;
  } ctrl_t;

  localparam ctrl_t c_ctrl_none = '{
    aluop:  c_alu_pass,
    alusrc: 1'b0,
    mov:    1'b0,
    load:   1'b0,
    store:  1'b0,
    branch: 1'b0,
    mul:    1'b0
  };

endpackage

`default_nettype wire

// File: rtl/control_decode.sv
// ============================================================================
// control_decode: combinational opcode/funct decode into a control bundle.
// Rev 1.0
// ============================================================================
`default_nettype none

module control_decode
  import control_pkg::*;
(
  input  logic [2:0] i_opcode,
  input  logic [1:0] i_funct,
  output ctrl_t      o_ctrl,
  output logic       o_illegal
);

  always_comb begin
    o_ctrl    = c_ctrl_none;
    o_illegal = 1'b0;
    unique case (i_opcode)
      c_op_alu: begin
        if (i_funct == c_fn_add)      o_ctrl.aluop = c_alu_add;
        else if (i_funct == c_fn_sub) o_ctrl.aluop = c_alu_sub;
        else                          o_illegal    = 1'b1;
      end
      // Memory ops compute base+offset; branch compares by subtraction.
      c_op_load: begin
        o_ctrl.aluop = c_alu_add;
        o_ctrl.load  = 1'b1;
      end
      c_op_store: begin
        o_ctrl.aluop = c_alu_add;
        o_ctrl.store = 1'b1;
      end
      c_op_imm: begin
        o_ctrl.aluop  = c_alu_add;
        o_ctrl.alusrc = 1'b1;
      end
      c_op_branch: begin
        o_ctrl.aluop  = c_alu_sub;
        o_ctrl.branch = 1'b1;
      end
      c_op_mov: begin
        o_ctrl.aluop = c_alu_pass;
        o_ctrl.mov   = 1'b1;
      end
      c_op_shift: o_ctrl.aluop = c_alu_lsl + {2'b00, i_funct};
      c_op_logic: begin
        if (i_funct == c_fn_and)     o_ctrl.aluop = c_alu_and;
        else if (i_funct == c_fn_or) o_ctrl.aluop = c_alu_or;
        else if (i_funct == c_fn_mul) begin
          o_ctrl.aluop = c_alu_mul;
          o_ctrl.mul   = 1'b1;
        end else begin
          o_illegal = 1'b1;
        end
      end
      default: o_illegal = 1'b1;
    endcase
    if (o_illegal) o_ctrl = c_ctrl_none;
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
// ============================================================================
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB controller with mul stretch
// and data-memory timeout. Rev 1.0
// ============================================================================
`default_nettype none

module multicycle_control
  import control_pkg::*;
#(
  parameter int OPWIDTH     = 4,
  parameter int MCODEBITS   = 9,
  parameter int MUL_CYCLES  = 2,
  parameter int MEM_TIMEOUT = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 start,
  input  logic                 halt,
  input  logic [MCODEBITS-1:0] instr,
  input  logic                 instr_valid,
  input  logic                 mem_ready,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 MemtoReg,
  output logic                 ALUSrc,
  output logic                 Branch,
  output logic                 Mov,
  output logic [OPWIDTH-1:0]   ALUOp,
  output logic                 busy,
  output logic                 illegal,
  output logic                 mem_timeout
);

  localparam int CNT_MAX = (MUL_CYCLES > MEM_TIMEOUT) ? MUL_CYCLES : MEM_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] c_mul_last = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] c_mem_last = CW'(MEM_TIMEOUT - 1);

  state_t               r_state;
  logic [MCODEBITS-1:0] r_ir;
  ctrl_t                r_ctrl;
  logic [CW-1:0]        r_cnt;
  logic                 r_illegal;
  logic                 r_mem_timeout;

  ctrl_t  w_dec;
  logic   w_dec_illegal;
  state_t w_boundary;

  assign w_boundary = halt ? S_IDLE : S_FETCH;

  control_decode u_decode (
    .i_opcode  (r_ir[MCODEBITS-1 -: 3]),
    .i_funct   (r_ir[MCODEBITS-4 -: 2]),
    .o_ctrl    (w_dec),
    .o_illegal (w_dec_illegal)
  );

  generate
    if (MCODEBITS > 5) begin : g_ir_tail
      logic w_unused_ir_tail;
      assign w_unused_ir_tail = ^r_ir[MCODEBITS-6:0];
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_ir          <= '0;
      r_ctrl        <= c_ctrl_none;
      r_cnt         <= '0;
      r_illegal     <= 1'b0;
      r_mem_timeout <= 1'b0;
    end else begin
      r_illegal     <= 1'b0;
      r_mem_timeout <= 1'b0;
      unique case (r_state)
        S_IDLE: if (start) r_state <= S_FETCH;
        S_FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (w_dec_illegal) begin
            r_illegal <= 1'b1;
            r_state   <= S_FETCH;
          end else begin
            r_ctrl  <= w_dec;
            r_cnt   <= '0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (r_ctrl.mul && (r_cnt != c_mul_last)) begin
            r_cnt <= r_cnt + CW'(1);
          end else if (r_ctrl.branch) begin
            r_state <= w_boundary;
          end else if (r_ctrl.load || r_ctrl.store) begin
            r_cnt   <= '0;
            r_state <= S_MEM;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          // r_cnt holds the number of MEM cycles already spent waiting.
          if (mem_ready) begin
            r_state <= r_ctrl.load ? S_WB : w_boundary;
          end else if (r_cnt == c_mem_last) begin
            r_mem_timeout <= 1'b1;
            r_state       <= w_boundary;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_WB:    r_state <= w_boundary;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // IRWrite/PCWrite qualify the fetch handshake in the same cycle it occurs.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    ALUSrc   = 1'b0;
    Branch   = 1'b0;
    Mov      = 1'b0;
    ALUOp    = OPWIDTH'(c_alu_pass);
    unique case (r_state)
      S_FETCH: begin
        IRWrite = instr_valid;
        PCWrite = instr_valid;
      end
      S_EXEC: begin
        ALUOp  = OPWIDTH'(r_ctrl.aluop);
        ALUSrc = r_ctrl.alusrc;
        Mov    = r_ctrl.mov;
        Branch = r_ctrl.branch;
      end
      S_MEM: begin
        MemRead  = r_ctrl.load;
        MemWrite = r_ctrl.store;
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = r_ctrl.load;
        Mov      = r_ctrl.mov;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign illegal     = r_illegal;
  assign mem_timeout = r_mem_timeout;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
// ============================================================================
// tb_multicycle_control: vector table, hand sequences and random instruction
// stream checked cycle by cycle against a per-instruction trace model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_control;

  localparam int MUL   = 3;
  localparam int MEMTO = 8;

  logic       Clk = 1'b0;
  logic       Reset, start, halt, instr_valid, mem_ready;
  logic [8:0] instr;
  logic       IRWrite, PCWrite, RegWrite, MemRead, MemWrite, MemtoReg;
  logic       ALUSrc, Branch, Mov, busy, illegal, mem_timeout;
  logic [3:0] ALUOp;

  always #5 Clk = ~Clk;

  multicycle_control #(
    .OPWIDTH(4), .MCODEBITS(9), .MUL_CYCLES(MUL), .MEM_TIMEOUT(MEMTO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .halt(halt), .instr(instr),
    .instr_valid(instr_valid), .mem_ready(mem_ready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUSrc(ALUSrc), .Branch(Branch), .Mov(Mov), .ALUOp(ALUOp),
    .busy(busy), .illegal(illegal), .mem_timeout(mem_timeout)
  );

  typedef struct packed {
    logic irw, pcw, rw, mr, mw, m2r, src, br, mov, busy, ill, mto;
    logic [3:0] op;
  } outs_t;

  typedef struct {
    outs_t exp;
    bit vld, rdy, free, bnd, idle, st;
  } step_t;

  typedef struct {
    logic [8:0] ins;
    int         dly;
    bit         hlt;
    bit         exp_rw;
    logic [3:0] exp_op;
  } vec_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  bit    in_idle;
  outs_t pend;

  function automatic outs_t actual();
    outs_t a;
    a = {IRWrite, PCWrite, RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc,
         Branch, Mov, busy, illegal, mem_timeout, ALUOp};
    return a;
  endfunction

  function automatic outs_t idle_o();
    outs_t o;
    o    = '0;
    o.op = 4'hF;
    return o;
  endfunction

  function automatic outs_t busy_o();
    outs_t o;
    o      = idle_o();
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic step_t mk(outs_t e, bit vld, bit rdy, bit free, bit bnd, bit idle, bit st);
    step_t s;
    s.exp = e; s.vld = vld; s.rdy = rdy; s.free = free;
    s.bnd = bnd; s.idle = idle; s.st = st;
    return s;
  endfunction

  // ALU operation an instruction should present in EXEC.
  function automatic logic [3:0] ref_aluop(logic [2:0] opc, logic [1:0] fn);
    case (opc)
      3'd0:    return 4'(fn);
      3'd4:    return 4'd1;
      3'd5:    return 4'hF;
      3'd6:    return 4'd2 + 4'(fn);
      3'd7:    return 4'd6 + 4'(fn);
      default: return 4'd0;
    endcase
  endfunction

  task automatic check(input string nm, input outs_t got, input outs_t exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  task automatic check_val(input string nm, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
  endtask

  task automatic cyc(input bit rst, input bit st, input bit hl, input bit vld, input bit rdy,
                     input logic [8:0] ins, input outs_t exp, input string nm,
                     output outs_t got);
    Reset = rst; start = st; halt = hl; instr_valid = vld; mem_ready = rdy; instr = ins;
    @(negedge Clk);
    got = actual();
    check(nm, got, exp);
    @(posedge Clk);
    #1;
  endtask

  // Build the expected cycle trace of one instruction and play it against the DUT.
  task automatic run_instr(input vec_t v, input int fwait, input int idle_extra, input string nm,
                           output bit saw_rw, output logic [3:0] ex_op);
    step_t      q[$];
    outs_t      o, got;
    logic [2:0] opc;
    logic [1:0] fn;
    bit         ill, ld, stv, brv, mv, mul, imm, to;
    int         n_mem;
    opc = v.ins[8:6];
    fn  = v.ins[5:4];
    ill = (opc == 3'd0 && fn[1]) || (opc == 3'd7 && fn == 2'd3);
    ld  = (opc == 3'd1);
    stv = (opc == 3'd2);
    imm = (opc == 3'd3);
    brv = (opc == 3'd4);
    mv  = (opc == 3'd5);
    mul = (opc == 3'd7 && fn == 2'd2);
    to  = (ld || stv) && (v.dly >= MEMTO);
    if (in_idle) begin
      for (int i = 0; i < idle_extra; i++) q.push_back(mk(idle_o(), 0, 0, 1, 0, 1, 0));
      q.push_back(mk(idle_o(), 0, 0, 1, 0, 1, 1));
    end
    for (int i = 0; i < fwait; i++) q.push_back(mk(busy_o(), 0, 0, 1, 0, 0, 0));
    o = busy_o(); o.irw = 1'b1; o.pcw = 1'b1;
    q.push_back(mk(o, 1, 0, 1, 0, 0, 0));
    q.push_back(mk(busy_o(), 0, 0, 1, 0, 0, 0));
    if (!ill) begin
      for (int i = 0; i < (mul ? MUL : 1); i++) begin
        o = busy_o(); o.op = ref_aluop(opc, fn); o.src = imm; o.mov = mv; o.br = brv;
        q.push_back(mk(o, 0, 0, 1, brv, 0, 0));
      end
      if (ld || stv) begin
        n_mem = to ? MEMTO : v.dly + 1;
        for (int i = 0; i < n_mem; i++) begin
          o = busy_o(); o.mr = ld; o.mw = stv;
          q.push_back(mk(o, 0, (i == v.dly), 0, (i == n_mem - 1) && (stv || to), 0, 0));
        end
      end
      if (!brv && !stv && !to) begin
        o = busy_o(); o.rw = 1'b1; o.m2r = ld; o.mov = mv;
        q.push_back(mk(o, 0, 0, 1, 1, 0, 0));
      end
    end
    q[0].exp.ill = pend.ill;
    q[0].exp.mto = pend.mto;
    pend     = '0;
    pend.ill = ill;
    pend.mto = to;
    in_idle  = v.hlt && !ill;
    saw_rw   = 1'b0;
    ex_op    = 4'hF;
    foreach (q[i]) begin
      cyc(1'b0,
          q[i].idle ? q[i].st : 1'($urandom),
          q[i].bnd ? v.hlt : 1'($urandom),
          q[i].vld,
          q[i].free ? 1'($urandom) : q[i].rdy,
          q[i].vld ? v.ins : 9'($urandom),
          q[i].exp, nm, got);
      saw_rw = saw_rw | got.rw;
      if (got.op != 4'hF) ex_op = got.op;
    end
  endtask

  vec_t       tbl[19];
  vec_t       rv;
  outs_t      got, o;
  bit         srw;
  logic [3:0] sop;

  initial begin
    tbl[0]  = '{9'b000_00_0101, 0,  1'b0, 1'b1, 4'd0};
    tbl[1]  = '{9'b000_01_0000, 0,  1'b0, 1'b1, 4'd1};
    tbl[2]  = '{9'b001_00_0011, 3,  1'b0, 1'b1, 4'd0};
    tbl[3]  = '{9'b010_00_0000, 0,  1'b0, 1'b0, 4'd0};
    tbl[4]  = '{9'b011_10_1111, 0,  1'b0, 1'b1, 4'd0};
    tbl[5]  = '{9'b100_00_0001, 0,  1'b0, 1'b0, 4'd1};
    tbl[6]  = '{9'b101_01_0000, 0,  1'b0, 1'b1, 4'hF};
    tbl[7]  = '{9'b110_01_0000, 0,  1'b0, 1'b1, 4'd3};
    tbl[8]  = '{9'b110_11_0000, 0,  1'b0, 1'b1, 4'd5};
    tbl[9]  = '{9'b111_00_0000, 0,  1'b0, 1'b1, 4'd6};
    tbl[10] = '{9'b111_01_0000, 0,  1'b0, 1'b1, 4'd7};
    tbl[11] = '{9'b111_10_0000, 0,  1'b0, 1'b1, 4'd8};
    tbl[12] = '{9'b111_11_0000, 0,  1'b0, 1'b0, 4'hF};
    tbl[13] = '{9'b000_10_0000, 0,  1'b1, 1'b0, 4'hF};
    tbl[14] = '{9'b010_00_0000, 99, 1'b0, 1'b0, 4'd0};
    tbl[15] = '{9'b001_00_0000, 7,  1'b0, 1'b1, 4'd0};
    tbl[16] = '{9'b001_00_0000, 8,  1'b1, 1'b0, 4'd0};
    tbl[17] = '{9'b111_10_0000, 0,  1'b1, 1'b1, 4'd8};
    tbl[18] = '{9'b100_00_0000, 0,  1'b1, 1'b0, 4'd1};

    Reset = 1'b1; start = 1'b1; halt = 1'b0; instr_valid = 1'b0; mem_ready = 1'b0; instr = '0;
    @(posedge Clk);
    #1;
    cyc(1, 1, 0, 0, 0, 9'd0, idle_o(), "reset_with_start", got);
    cyc(0, 0, 0, 0, 0, 9'd0, idle_o(), "idle_after_reset", got);
    in_idle = 1'b1;
    pend    = '0;

    foreach (tbl[i]) begin
      run_instr(tbl[i], 0, 0, $sformatf("vec%0d", i), srw, sop);
      check_val($sformatf("vec%0d_regwrite", i), int'(srw), int'(tbl[i].exp_rw));
      check_val($sformatf("vec%0d_aluop", i), int'(sop), int'(tbl[i].exp_op));
    end

    // Reset in the middle of a load's MEM wait.
    o = in_idle ? idle_o() : busy_o();
    o.ill = pend.ill; o.mto = pend.mto;
    cyc(1, 0, 0, 0, 0, 9'd0, o, "pre_reset", got);
    cyc(0, 1, 0, 0, 0, 9'd0, idle_o(), "rm_idle", got);
    o = busy_o(); o.irw = 1'b1; o.pcw = 1'b1;
    cyc(0, 0, 0, 1, 0, 9'b001_00_0000, o, "rm_fetch", got);
    cyc(0, 0, 0, 0, 0, 9'd0, busy_o(), "rm_decode", got);
    o = busy_o(); o.op = 4'd0;
    cyc(0, 0, 0, 0, 0, 9'd0, o, "rm_exec", got);
    o = busy_o(); o.mr = 1'b1;
    cyc(0, 0, 0, 0, 0, 9'd0, o, "rm_mem1", got);
    cyc(1, 1, 0, 0, 0, 9'd0, o, "rm_mem2", got);
    cyc(0, 0, 0, 0, 1, 9'd0, idle_o(), "rm_after_reset", got);
    in_idle = 1'b1;
    pend    = '0;

    for (int k = 0; k < 80; k++) begin
      rv.ins    = 9'($urandom);
      rv.dly    = $urandom_range(0, 10);
      rv.hlt    = ($urandom_range(0, 4) == 0);
      rv.exp_rw = 1'b0;
      rv.exp_op = 4'hF;
      run_instr(rv, $urandom_range(0, 2), $urandom_range(0, 1), $sformatf("rnd%0d", k), srw, sop);
    end

    o = in_idle ? idle_o() : busy_o();
    o.ill = pend.ill; o.mto = pend.mto;
    cyc(0, 0, 0, 0, 0, 9'd0, o, "final", got);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
